// File: rtl/reg_sweep_writer_pkg.sv
// Shared types and helpers for the register-sweep writer: FSM state encoding
// and the effective-stride rule used by the address generator.
package reg_sweep_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } sweep_state_e;

  // A zero stride would stall the sweep on one register, so it means 1.
  function automatic int unsigned eff_stride(input int unsigned stride);
    return (stride == 0) ? 32'd1 : stride;
  endfunction

endpackage

// File: rtl/reg_sweep_writer_sweep_addr_gen.sv
// Address/remaining-count datapath for the sweep: loads the config, steps the
// address by the effective stride and reports the last write and boundary clips.
module sweep_addr_gen
  import reg_sweep_writer_pkg::*;
#(
  parameter int REG_BITS    = 5,
  parameter int CNT_BITS    = 4,
  parameter int STRIDE_BITS = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   step,
  input  logic [REG_BITS-1:0]    start_reg,
  input  logic [CNT_BITS-1:0]    count,
  input  logic [STRIDE_BITS-1:0] stride,
  input  logic                   direction,
  output logic [REG_BITS-1:0]    addr,
  output logic [REG_BITS-1:0]    next_addr,
  output logic                   last,
  output logic                   clip
);

  logic [REG_BITS-1:0]    addr_q, addr_d;
  logic [CNT_BITS-1:0]    rem_q, rem_d;
  logic [STRIDE_BITS-1:0] stride_q, stride_d;
  logic                   dir_q, dir_d;

  logic [REG_BITS:0] step_w;
  logic [REG_BITS:0] ext_addr;
  logic [REG_BITS:0] sum;
  logic              out_of_range;

  // One extra bit catches both carry past the top and borrow below zero.
  always_comb begin
    step_w       = (REG_BITS+1)'(eff_stride(32'(stride_q)));
    ext_addr     = {1'b0, addr_q};
    sum          = dir_q ? (ext_addr + step_w) : (ext_addr - step_w);
    out_of_range = sum[REG_BITS];
    next_addr    = sum[REG_BITS-1:0];
    last         = (rem_q == CNT_BITS'(1));
    clip         = (WRAP == 1'b0) && out_of_range && !last;
    addr         = addr_q;
  end

  always_comb begin
    addr_d   = addr_q;
    rem_d    = rem_q;
    stride_d = stride_q;
    dir_d    = dir_q;
    if (load) begin
      addr_d   = start_reg;
      rem_d    = count;
      stride_d = stride;
      dir_d    = direction;
    end else if (step) begin
      addr_d = next_addr;
      rem_d  = rem_q - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      rem_q    <= '0;
      stride_q <= '0;
      dir_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      stride_q <= stride_d;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: rtl/reg_sweep_writer.sv
// Register-sweep sequencer: arm with go, launch on go falling, then emit one
// register number per cycle with wr_en. All outputs are registered (Moore).
module reg_sweep_writer
  import reg_sweep_writer_pkg::*;
#(
  parameter int REG_BITS    = 5,
  parameter int CNT_BITS    = 4,
  parameter int STRIDE_BITS = 2,
  parameter bit WRAP        = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   go,
  input  logic                   direction,
  input  logic [REG_BITS-1:0]    start_reg,
  input  logic [CNT_BITS-1:0]    count,
  input  logic [STRIDE_BITS-1:0] stride,
  output logic [REG_BITS-1:0]    regnum,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output sweep_state_e           dbg_state
);

  sweep_state_e        state_q, state_d;
  logic [REG_BITS-1:0] regnum_q, regnum_d;
  logic                wr_en_q, wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;

  logic                load, step;
  logic [REG_BITS-1:0] addr, next_addr;
  logic                last, clip;

  sweep_addr_gen #(
    .REG_BITS   (REG_BITS),
    .CNT_BITS   (CNT_BITS),
    .STRIDE_BITS(STRIDE_BITS),
    .WRAP       (WRAP)
  ) u_addr_gen (
    .clk      (clock),
    .rst      (reset),
    .load     (load),
    .step     (step),
    .start_reg(start_reg),
    .count    (count),
    .stride   (stride),
    .direction(direction),
    .addr     (addr),
    .next_addr(next_addr),
    .last     (last),
    .clip     (clip)
  );

  // Outputs are computed for the state being entered, so they line up with
  // state_q one cycle later without any input-to-output path.
  always_comb begin
    state_d   = state_q;
    regnum_d  = '0;
    wr_en_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      S_IDLE: begin
        overrun_d = 1'b0;
        if (go) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        overrun_d = 1'b0;
        busy_d    = 1'b1;
        if (!go) begin
          if (count != '0) begin
            state_d  = S_WRITE;
            load     = 1'b1;
            wr_en_d  = 1'b1;
            regnum_d = start_reg;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_WRITE: begin
        step = 1'b1;
        // An abort wins over completion: the current write already issued.
        if (go) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
        end else if (last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (clip) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          overrun_d = 1'b1;
        end else begin
          wr_en_d  = 1'b1;
          busy_d   = 1'b1;
          regnum_d = next_addr;
        end
      end
      S_DONE: begin
        if (go) begin
          state_d   = S_LOAD;
          busy_d    = 1'b1;
          overrun_d = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        overrun_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      regnum_q  <= '0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      regnum_q  <= regnum_d;
      wr_en_q   <= wr_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign regnum    = regnum_q;
  assign wr_en     = wr_en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

  // unused by the FSM itself; the registered regnum already tracks it
  logic unused_addr;
  assign unused_addr = ^addr;

endmodule
